// File: rtl/jk_counter_reg.sv
// jk_counter_reg: WIDTH-bit register bank whose bits work as JK flip-flops
// and which can also count up, count down or load in parallel. TC is a
// registered one-cycle pulse that marks a step taken from the counting limit.
// Optional feature macro: JKREG_SAT_EN. When it is defined, the count modes
// saturate at the limits instead of wrapping.
module jk_counter_reg #(
  parameter int                 WIDTH       = 4,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             Clock,
  input  logic             ClearN,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             TC
);

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  mode_t            mode;
  logic [WIDTH-1:0] q_reg;
  logic             tc_reg;
  logic [WIDTH-1:0] q_next;
  logic             tc_next;
  logic             at_max;
  logic             at_min;

  assign mode   = mode_t'(Mode);
  assign at_max = &q_reg;
  assign at_min = ~|q_reg;

  // Next-state value for an enabled, non-cleared edge, chosen by mode
  always_comb begin
    q_next  = q_reg;
    tc_next = 1'b0;
    case (mode)
      MODE_JK: begin
        // Characteristic JK equation applied bitwise: set, reset, hold, toggle
        q_next = (J & ~q_reg) | (~K & q_reg);
      end
      MODE_UP: begin
        tc_next = at_max;
`ifdef JKREG_SAT_EN
        q_next  = at_max ? q_reg : q_reg + ONE;
`else
        q_next  = q_reg + ONE;
`endif
      end
      MODE_DOWN: begin
        tc_next = at_min;
`ifdef JKREG_SAT_EN
        q_next  = at_min ? q_reg : q_reg - ONE;
`else
        q_next  = q_reg - ONE;
`endif
      end
      MODE_LOAD: begin
        q_next = D;
      end
      default: begin
        q_next  = q_reg;
        tc_next = 1'b0;
      end
    endcase
  end

  // State register: clear beats enable, enable beats the mode logic
  always_ff @(posedge Clock) begin
    if (!ClearN) begin
      q_reg  <= RESET_VALUE;
      tc_reg <= 1'b0;
    end else if (!En) begin
      q_reg  <= q_reg;
      tc_reg <= 1'b0;
    end else begin
      q_reg  <= q_next;
      tc_reg <= tc_next;
    end
  end

  assign Q  = q_reg;
  assign QN = ~q_reg;
  assign TC = tc_reg;

endmodule

// File: tb/tb_jk_counter_reg.sv
// tb_jk_counter_reg: directed checks of jk_counter_reg with WIDTH=4 and
// RESET_VALUE=4'hA. Expected values are worked out by hand per step.
module tb_jk_counter_reg;

  localparam int         W  = 4;
  localparam logic [3:0] RV = 4'hA;

  logic         Clock;
  logic         ClearN;
  logic         En;
  logic [1:0]   Mode;
  logic [W-1:0] J;
  logic [W-1:0] K;
  logic [W-1:0] D;
  logic [W-1:0] Q;
  logic [W-1:0] QN;
  logic         TC;

  int vectors    = 0;
  int miscompares = 0;

  jk_counter_reg #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .Clock (Clock),
    .ClearN(ClearN),
    .En    (En),
    .Mode  (Mode),
    .J     (J),
    .K     (K),
    .D     (D),
    .Q     (Q),
    .QN    (QN),
    .TC    (TC)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Drive one set of inputs, take one rising edge, settle before sampling
  task automatic applyStimulus(input logic clr_n, input logic en,
                               input logic [1:0] mode, input logic [W-1:0] j,
                               input logic [W-1:0] k, input logic [W-1:0] d);
    ClearN = clr_n;
    En     = en;
    Mode   = mode;
    J      = j;
    K      = k;
    D      = d;
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkQT(input string tag, input logic [W-1:0] exp_q,
                         input logic exp_tc);
    checkOutput({tag, ".Q"}, Q, exp_q);
    checkOutput({tag, ".TC"}, {3'b000, TC}, {3'b000, exp_tc});
  endtask

  initial begin
    // Reset held for two edges while counting is requested
    applyStimulus(1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
    applyStimulus(1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
    checkQT("reset", 4'hA, 1'b0);
    checkOutput("reset.QN", QN, 4'h5);

    // First functional edge after release
    applyStimulus(1'b1, 1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
    checkQT("release", 4'hB, 1'b0);

    // JK per-bit: Q=0101, J=1100, K=1010 -> toggle, set, reset, hold
    applyStimulus(1'b1, 1'b1, 2'b11, 4'h0, 4'h0, 4'b0101);
    checkQT("load5", 4'b0101, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b00, 4'b1100, 4'b1010, 4'h0);
    checkQT("jk", 4'b1101, 1'b0);
    checkOutput("jk.QN", QN, 4'b0010);
    applyStimulus(1'b1, 1'b1, 2'b00, 4'hF, 4'hF, 4'h0);
    checkQT("jk_toggle", 4'b0010, 1'b0);

    // Up from E through the top
    applyStimulus(1'b1, 1'b1, 2'b11, 4'h0, 4'h0, 4'hE);
    checkQT("loadE", 4'hE, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
    checkQT("up1", 4'hF, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
`ifdef JKREG_SAT_EN
    checkQT("up2", 4'hF, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
    checkQT("up3", 4'hF, 1'b1);
`else
    checkQT("up2", 4'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
    checkQT("up3", 4'h1, 1'b0);
`endif

    // Down from 1 through zero
    applyStimulus(1'b1, 1'b1, 2'b11, 4'h0, 4'h0, 4'h1);
    checkQT("load1", 4'h1, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b10, 4'h0, 4'h0, 4'h0);
    checkQT("down1", 4'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b10, 4'h0, 4'h0, 4'h0);
`ifdef JKREG_SAT_EN
    checkQT("down2", 4'h0, 1'b1);
`else
    checkQT("down2", 4'hF, 1'b1);
`endif

    // A load right after a limit step drops TC
    applyStimulus(1'b1, 1'b1, 2'b11, 4'h0, 4'h0, 4'h3);
    checkQT("load3", 4'h3, 1'b0);

    // Enable gating while counting up
    applyStimulus(1'b1, 1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
    checkQT("en1", 4'h4, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b01, 4'h0, 4'h0, 4'h0);
    checkQT("en0", 4'h4, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
    checkQT("en1b", 4'h5, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b01, 4'h0, 4'h0, 4'h0);
    checkQT("clr_en0", RV, 1'b0);

    // Disabled edge right after a limit step clears TC and holds Q
    applyStimulus(1'b1, 1'b1, 2'b11, 4'h0, 4'h0, 4'hF);
    applyStimulus(1'b1, 1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
`ifdef JKREG_SAT_EN
    checkQT("wrapF", 4'hF, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b01, 4'h0, 4'h0, 4'h0);
    checkQT("hold_tc", 4'hF, 1'b0);
`else
    checkQT("wrapF", 4'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b01, 4'h0, 4'h0, 4'h0);
    checkQT("hold_tc", 4'h0, 1'b0);
`endif

    // Clear in the middle of a count, then resume from the reset value
    applyStimulus(1'b1, 1'b1, 2'b11, 4'h0, 4'h0, 4'h6);
    applyStimulus(1'b1, 1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
    checkQT("count7", 4'h7, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
    checkQT("midclr", RV, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
    checkQT("resume", 4'hB, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b10, 4'h0, 4'h0, 4'h0);
    checkQT("down_after", 4'hA, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
